conv2_bias_relu_unit: RTL

Post-accumulation stage for conv2, directly downstream of the conv2 MAC accumulator and a consumer of the conv2 bias memory. For each accumulated partial sum it:
- drives the filter index to the bias memory and adds the returned 32-bit bias;
- applies ReLU, then a rounded arithmetic right shift;
- saturates to a 16-bit activation and hands it to the next layer over a valid/ready handshake.

It sequences filters and output positions for one full layer pass per `start` pulse.

---
 rtl/conv2_bias_relu_unit_if.sv | 33 +++
 rtl/conv2_bias_relu_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/conv2_bias_relu_unit_if.sv
// Signal bundle for the conv2 bias/ReLU stage: accumulator input stream,
// bias-memory lookup, activation output stream and pass control.
interface conv2_bias_relu_unit_if;
  logic               start;
  logic               acc_valid;
  logic signed [31:0] acc_data;
  logic               acc_ready;
  logic               bias_start;
  logic [3:0]         bias_filter;
  logic signed [31:0] bias_b;
  logic               bias_done;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [3:0]         out_filter;
  logic               out_last;
  logic               out_ready;
  logic               busy;
  logic               done;

  // The unit itself.
  modport master (
    input  start, acc_valid, acc_data, bias_b, bias_done, out_ready,
    output acc_ready, bias_start, bias_filter, out_valid, out_data,
           out_filter, out_last, busy, done
  );

  // The surrounding accumulator, bias memory and downstream layer.
  modport slave (
    output start, acc_valid, acc_data, bias_b, bias_done, out_ready,
    input  acc_ready, bias_start, bias_filter, out_valid, out_data,
           out_filter, out_last, busy, done
  );
endinterface

// File: rtl/conv2_bias_relu_unit.sv
// conv2 post-accumulation stage: bias add, ReLU, rounded right shift and
// 16-bit saturation, sequencing every (position, filter) pair of one layer
// pass per start pulse and handing activations downstream via valid/ready.
module conv2_bias_relu_unit #(
  parameter int NUM_FILTERS   = 10,
  parameter int NUM_POSITIONS = 64,
  parameter int SHIFT         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv2_bias_relu_unit_if.master io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  localparam int              POS_W     = (NUM_POSITIONS > 1) ? $clog2(NUM_POSITIONS) : 1;
  localparam logic [3:0]      FILT_LAST = 4'(NUM_FILTERS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_POSITIONS - 1);
  localparam logic [33:0]     ROUND     = 34'd1 << (SHIFT - 1);
  localparam logic [33:0]     ACT_MAX   = 34'd32767;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_filt_cnt;
  logic [POS_W-1:0]   r_pos_cnt;
  logic               r_out_valid;
  logic signed [15:0] r_out_data;
  logic [3:0]         r_out_filter;
  logic               r_out_last;
  logic               r_done;

  logic               w_acc_ready;
  logic               w_bias_start;
  logic               w_busy;
  logic               w_accept;
  logic               w_last_pair;
  logic               w_flush_exit;
  logic signed [32:0] w_sum;
  logic [33:0]        w_rounded;
  logic [33:0]        w_shifted;
  logic signed [15:0] w_act;

  assign w_accept     = io_bus.acc_valid && w_acc_ready;
  assign w_last_pair  = (r_filt_cnt == FILT_LAST) && (r_pos_cnt == POS_LAST);
  // The last activation leaves the output register this cycle (or it is already empty).
  assign w_flush_exit = (r_state == S_FLUSH) && (!r_out_valid || io_bus.out_ready);

  // Widen both operands by one bit so the bias add can never wrap.
  assign w_sum = {io_bus.acc_data[31], io_bus.acc_data} + {io_bus.bias_b[31], io_bus.bias_b};

  // ReLU, round-half-up shift and clamp; the rounding path only matters for positive sums.
  always_comb begin
    w_rounded = {1'b0, w_sum} + ROUND;
    w_shifted = w_rounded >> SHIFT;
    if (w_sum[32] || (w_sum == 33'sd0)) begin
      w_act = 16'sd0;
    end else if (w_shifted > ACT_MAX) begin
      w_act = 16'sh7FFF;
    end else begin
      w_act = w_shifted[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_last_pair) w_state_next = S_FLUSH;
      S_FLUSH: if (w_flush_exit) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; accept needs a bias and room in the output register.
  always_comb begin
    w_acc_ready  = 1'b0;
    w_bias_start = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_bias_start = 1'b1;
        w_busy       = 1'b1;
        w_acc_ready  = io_bus.bias_done && (!r_out_valid || io_bus.out_ready);
      end
      S_FLUSH: w_busy = 1'b1;
      default: ;
    endcase
  end

  // Filter/position sequencing: cleared when a pass starts, stepped per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_cnt <= '0;
      r_pos_cnt  <= '0;
    end else if ((r_state == S_IDLE) && io_bus.start) begin
      r_filt_cnt <= '0;
      r_pos_cnt  <= '0;
    end else if (w_accept) begin
      if (r_filt_cnt == FILT_LAST) begin
        r_filt_cnt <= '0;
        r_pos_cnt  <= r_pos_cnt + 1'b1;
      end else begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end
    end
  end

  // Output register: reload on accept, empty on drain without a new accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_filter <= '0;
      r_out_last   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_act;
      r_out_filter <= r_filt_cnt;
      r_out_last   <= w_last_pair;
    end else if (r_out_valid && io_bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // One-cycle done pulse on the FLUSH to IDLE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_flush_exit;
    end
  end

  assign io_bus.acc_ready   = w_acc_ready;
  assign io_bus.bias_start  = w_bias_start;
  assign io_bus.bias_filter = r_filt_cnt;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_data    = r_out_data;
  assign io_bus.out_filter  = r_out_filter;
  assign io_bus.out_last    = r_out_last;
  assign io_bus.busy        = w_busy;
  assign io_bus.done        = r_done;

endmodule
